// File: rtl/thread_stack_file.sv
// Per-thread operand-stack register file, 1-cycle registered response.
// Optional TSF_WATERMARK_EN adds per-thread high-watermark output hiwat.
module thread_stack_file #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 256,
  parameter int NTHREADS = 2,
  parameter int AW       = $clog2(DEPTH),
  parameter int TW       = (NTHREADS > 1) ? $clog2(NTHREADS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  input  logic [TW-1:0]       cmd_tid,
  input  logic [2:0]          cmd_op,
  input  logic [AW-1:0]       cmd_arg,
  input  logic [WIDTH-1:0]    cmd_wdata,
  input  logic                clr_valid,
  input  logic [TW-1:0]       clr_tid,
  output logic                rsp_valid,
  output logic [WIDTH-1:0]    rsp_top,
  output logic [WIDTH-1:0]    rsp_next,
  output logic [AW:0]         rsp_count,
  output logic                rsp_fault,
`ifdef TSF_WATERMARK_EN
  output logic [NTHREADS*(AW+1)-1:0] hiwat,
`endif
  output logic [NTHREADS-1:0] ovf_flags,
  output logic [NTHREADS-1:0] unf_flags
);

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_DUP  = 3'd3,
    OP_GET  = 3'd4,
    OP_PUT  = 3'd5,
    OP_REPL = 3'd6,
    OP_BAD  = 3'd7
  } op_e;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [NTHREADS][DEPTH];
  logic [AW:0]      cnt [NTHREADS];

  logic [TW-1:0]    tid;
  logic [TW-1:0]    ctid;
  logic [AW:0]      c;
  logic [AW-1:0]    ci;
  logic [AW-1:0]    top_i;
  logic [AW-1:0]    sec_i;
  logic [AW-1:0]    off_i;
  logic [WIDTH-1:0] m_top;
  logic [WIDTH-1:0] m_off;
  logic             full;
  logic             arg_ge_c;
  logic             collide;
  logic             go;

  // Single-thread builds have a dummy tid bit; pin it to thread 0.
  assign tid  = (NTHREADS > 1) ? cmd_tid : '0;
  assign ctid = (NTHREADS > 1) ? clr_tid : '0;

  assign c        = cnt[tid];
  assign ci       = c[AW-1:0];
  assign top_i    = ci - 1'b1;
  assign sec_i    = ci - AW'(2);
  assign off_i    = ci - 1'b1 - cmd_arg;
  assign m_top    = mem[tid][top_i];
  assign m_off    = mem[tid][off_i];
  assign full     = (c == FULL);
  assign arg_ge_c = ({1'b0, cmd_arg} >= c);
  assign collide  = clr_valid && (ctid == tid);
  assign go       = cmd_valid && !collide;

  logic             we;
  logic [AW-1:0]    widx;
  logic [WIDTH-1:0] wdat;
  logic [AW:0]      nc;
  logic             ovf;
  logic             unf;
  logic             bad;
  logic             fault;

  always_comb begin
    we   = 1'b0;
    widx = ci;
    wdat = cmd_wdata;
    nc   = c;
    ovf  = 1'b0;
    unf  = 1'b0;
    bad  = 1'b0;
    unique case (op_e'(cmd_op))
      OP_NOP: ;
      OP_PUSH: begin
        if (full) ovf = 1'b1;
        else begin
          we = 1'b1;
          nc = c + 1'b1;
        end
      end
      OP_POP: begin
        if ({1'b0, cmd_arg} > c) unf = 1'b1;
        else nc = c - {1'b0, cmd_arg};
      end
      OP_DUP: begin
        if (c == '0) unf = 1'b1;
        else if (full) ovf = 1'b1;
        else begin
          we   = 1'b1;
          wdat = m_top;
          nc   = c + 1'b1;
        end
      end
      OP_GET: begin
        if (arg_ge_c) unf = 1'b1;
        else if (full) ovf = 1'b1;
        else begin
          we   = 1'b1;
          wdat = m_off;
          nc   = c + 1'b1;
        end
      end
      OP_PUT: begin
        if (arg_ge_c) unf = 1'b1;
        else begin
          we   = 1'b1;
          widx = off_i;
          wdat = m_top;
        end
      end
      OP_REPL: begin
        if (c < (AW+1)'(2)) unf = 1'b1;
        else begin
          we   = 1'b1;
          widx = sec_i;
          nc   = c - 1'b1;
        end
      end
      default: bad = 1'b1;
    endcase
    fault = ovf | unf | bad;
    if (fault) begin
      we = 1'b0;
      nc = c;
    end
  end

  // Post-command top/next, forwarding the write issued this cycle.
  logic [AW-1:0]    nt_i;
  logic [AW-1:0]    ns_i;
  logic [WIDTH-1:0] r_top;
  logic [WIDTH-1:0] r_next;

  assign nt_i = nc[AW-1:0] - 1'b1;
  assign ns_i = nc[AW-1:0] - AW'(2);

  always_comb begin
    r_top  = '0;
    r_next = '0;
    if (nc != '0)
      r_top = (we && widx == nt_i) ? wdat : mem[tid][nt_i];
    if (nc >= (AW+1)'(2))
      r_next = (we && widx == ns_i) ? wdat : mem[tid][ns_i];
  end

  always_ff @(posedge clk) begin
    if (!reset && go && we)
      mem[tid][widx] <= wdat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int t = 0; t < NTHREADS; t++) cnt[t] <= '0;
      ovf_flags <= '0;
      unf_flags <= '0;
    end else begin
      for (int t = 0; t < NTHREADS; t++) begin
        if (clr_valid && ctid == TW'(t)) begin
          cnt[t]       <= '0;
          ovf_flags[t] <= 1'b0;
          unf_flags[t] <= 1'b0;
        end else if (go && tid == TW'(t)) begin
          cnt[t] <= nc;
          if (ovf) ovf_flags[t] <= 1'b1;
          if (unf) unf_flags[t] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_top   <= '0;
      rsp_next  <= '0;
      rsp_count <= '0;
      rsp_fault <= 1'b0;
    end else begin
      rsp_valid <= cmd_valid;
      if (cmd_valid) begin
        rsp_fault <= collide | fault;
        rsp_count <= collide ? '0 : nc;
        rsp_top   <= collide ? '0 : r_top;
        rsp_next  <= collide ? '0 : r_next;
      end
    end
  end

`ifdef TSF_WATERMARK_EN
  logic [AW:0] hw [NTHREADS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int t = 0; t < NTHREADS; t++) hw[t] <= '0;
    end else begin
      for (int t = 0; t < NTHREADS; t++) begin
        if (clr_valid && ctid == TW'(t)) hw[t] <= '0;
        else if (go && tid == TW'(t) && nc > hw[t]) hw[t] <= nc;
      end
    end
  end

  for (genvar g = 0; g < NTHREADS; g++) begin : g_hw
    assign hiwat[g*(AW+1) +: AW+1] = hw[g];
  end
`endif

endmodule

// File: tb/tb_thread_stack_file.sv
// Directed self-checking bench for thread_stack_file (W=16, D=8, T=2).
// Watermark checks compile in when TSF_WATERMARK_EN is defined.
module tb_thread_stack_file;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int NT    = 2;
  localparam int AW    = 3;
  localparam int TW    = 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            cmd_valid;
  logic [TW-1:0]   cmd_tid;
  logic [2:0]      cmd_op;
  logic [AW-1:0]   cmd_arg;
  logic [WIDTH-1:0] cmd_wdata;
  logic            clr_valid;
  logic [TW-1:0]   clr_tid;
  logic            rsp_valid;
  logic [WIDTH-1:0] rsp_top;
  logic [WIDTH-1:0] rsp_next;
  logic [AW:0]     rsp_count;
  logic            rsp_fault;
  logic [NT-1:0]   ovf_flags;
  logic [NT-1:0]   unf_flags;
`ifdef TSF_WATERMARK_EN
  logic [NT*(AW+1)-1:0] hiwat;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  thread_stack_file #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NTHREADS(NT)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_tid(cmd_tid),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .cmd_wdata(cmd_wdata),
    .clr_valid(clr_valid), .clr_tid(clr_tid),
    .rsp_valid(rsp_valid), .rsp_top(rsp_top),
    .rsp_next(rsp_next), .rsp_count(rsp_count),
    .rsp_fault(rsp_fault),
`ifdef TSF_WATERMARK_EN
    .hiwat(hiwat),
`endif
    .ovf_flags(ovf_flags), .unf_flags(unf_flags)
  );

  localparam logic [2:0] NOP = 0, PUSH = 1, POP = 2, DUP = 3;
  localparam logic [2:0] GET = 4, PUT = 5, REPL = 6, BAD = 7;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic cv, input logic [TW-1:0] t,
                      input logic [2:0] op, input logic [AW-1:0] arg,
                      input logic [WIDTH-1:0] wd,
                      input logic lv, input logic [TW-1:0] lt);
    cmd_valid = cv;
    cmd_tid   = t;
    cmd_op    = op;
    cmd_arg   = arg;
    cmd_wdata = wd;
    clr_valid = lv;
    clr_tid   = lt;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    clr_valid = 1'b0;
  endtask

  task automatic cmd(input logic [TW-1:0] t, input logic [2:0] op,
                     input logic [AW-1:0] arg, input logic [WIDTH-1:0] wd);
    step(1'b1, t, op, arg, wd, 1'b0, 1'b0);
  endtask

  task automatic rsp(input string tag, input logic [WIDTH-1:0] top,
                     input logic [WIDTH-1:0] nxt, input logic [AW:0] cnt,
                     input logic flt);
    chk({tag, ".valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".top"},   32'(rsp_top),   32'(top));
    chk({tag, ".next"},  32'(rsp_next),  32'(nxt));
    chk({tag, ".count"}, 32'(rsp_count), 32'(cnt));
    chk({tag, ".fault"}, 32'(rsp_fault), 32'(flt));
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_tid   = '0;
    cmd_op    = '0;
    cmd_arg   = '0;
    cmd_wdata = '0;
    clr_valid = 1'b0;
    clr_tid   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 32'(rsp_valid), 0);
    chk("rst.count", 32'(rsp_count), 0);
    chk("rst.top",   32'(rsp_top),   0);
    chk("rst.fault", 32'(rsp_fault), 0);
    chk("rst.ovf",   32'(ovf_flags), 0);
    chk("rst.unf",   32'(unf_flags), 0);
    reset = 1'b0;

    cmd(0, PUSH, 0, 16'h0011); rsp("p1", 16'h0011, 0, 1, 0);
    cmd(0, PUSH, 0, 16'h0022); rsp("p2", 16'h0022, 16'h0011, 2, 0);
    cmd(0, REPL, 0, 16'h0033); rsp("repl", 16'h0033, 0, 1, 0);
    @(posedge clk); #1;
    chk("hold.valid", 32'(rsp_valid), 0);
    chk("hold.top",   32'(rsp_top),   32'h33);
    cmd(0, POP, 1, 0);         rsp("pop1", 0, 0, 0, 0);

    for (int i = 1; i <= 8; i++) begin
      cmd(1, PUSH, 0, 16'(i));
      chk("t1push.count", 32'(rsp_count), 32'(i));
    end
    rsp("t1full", 16'h0008, 16'h0007, 8, 0);
    cmd(1, PUSH, 0, 16'h0009); rsp("t1ovf", 16'h0008, 16'h0007, 8, 1);
    chk("t1ovf.flags", 32'(ovf_flags), 32'b10);
    cmd(0, NOP, 0, 0);         rsp("t0iso", 0, 0, 0, 0);

    cmd(0, PUSH, 0, 16'h000A);
    cmd(0, PUSH, 0, 16'h000B);
    cmd(0, PUSH, 0, 16'h000C); rsp("abc", 16'h000C, 16'h000B, 3, 0);
    cmd(0, GET, 2, 0);         rsp("get2", 16'h000A, 16'h000C, 4, 0);
    cmd(0, PUT, 3, 0);         rsp("put3", 16'h000A, 16'h000C, 4, 0);
    cmd(0, POP, 3, 0);         rsp("pop3", 16'h000A, 0, 1, 0);
    cmd(0, POP, 2, 0);         rsp("unf", 16'h000A, 0, 1, 1);
    chk("unf.flags", 32'(unf_flags), 32'b01);
    cmd(0, POP, 0, 0);         rsp("pop0", 16'h000A, 0, 1, 0);
    cmd(0, DUP, 0, 0);         rsp("dup", 16'h000A, 16'h000A, 2, 0);
    cmd(0, BAD, 0, 0);         rsp("op7", 16'h000A, 16'h000A, 2, 1);
    chk("op7.ovf", 32'(ovf_flags), 32'b10);
    chk("op7.unf", 32'(unf_flags), 32'b01);

    step(1, 0, PUSH, 0, 16'h0077, 1, 0);
    rsp("clrhit", 0, 0, 0, 1);
    chk("clrhit.unf", 32'(unf_flags), 0);
    cmd(0, NOP, 0, 0);         rsp("clrhit.nop", 0, 0, 0, 0);
    cmd(1, POP, 7, 0);         rsp("t1pop7", 16'h0001, 0, 1, 0);
    cmd(0, PUSH, 0, 16'h0099); rsp("t0p", 16'h0099, 0, 1, 0);
    step(1, 1, PUSH, 0, 16'h0044, 1, 0);
    rsp("clrmiss", 16'h0044, 16'h0001, 2, 0);
    chk("clrmiss.ovf", 32'(ovf_flags), 32'b10);
    cmd(0, NOP, 0, 0);         rsp("clrmiss.t0", 0, 0, 0, 0);

    for (int i = 0; i < 3; i++) begin
      cmd(0, PUSH, 0, 16'h0100);
      cmd(1, PUSH, 0, 16'h0200);
    end
    cmd(0, POP, 5, 0);
    chk("pre.unf", 32'(unf_flags), 32'b01);
    reset = 1'b1;
    cmd(1, PUSH, 0, 16'h0300);
    reset = 1'b0;
    chk("mid.valid", 32'(rsp_valid), 0);
    chk("mid.count", 32'(rsp_count), 0);
    chk("mid.top",   32'(rsp_top),   0);
    chk("mid.ovf",   32'(ovf_flags), 0);
    chk("mid.unf",   32'(unf_flags), 0);
    cmd(1, PUSH, 0, 16'h5555); rsp("post", 16'h5555, 0, 1, 0);

`ifdef TSF_WATERMARK_EN
    chk("hw.rst", 32'(hiwat[AW:0]), 0);
    for (int i = 0; i < 5; i++) cmd(0, PUSH, 0, 16'(i));
    cmd(0, POP, 3, 0);
    cmd(0, PUSH, 0, 16'h00EE); rsp("hw.p", 16'h00EE, 16'h0001, 3, 0);
    chk("hw.t0", 32'(hiwat[AW:0]), 5);
    chk("hw.t1", 32'(hiwat[2*AW+1:AW+1]), 1);
    step(0, 0, NOP, 0, 0, 1, 0);
    chk("hw.clr", 32'(hiwat[AW:0]), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
